wb_i2c_ctrl: RTL and testbench

//  Wishbone-classic slave that sequences the existing i2c_master from the CPU bus.

---
 rtl/wb_i2c_ctrl_pkg.sv | 30 +++
 rtl/wb_i2c_ctrl_if.sv | 25 ++
 rtl/i2c_byte_fifo.sv | 57 +++++
 rtl/wb_i2c_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_wb_i2c_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_i2c_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_i2c_ctrl_pkg : register offsets, STATUS bit indices and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package wb_i2c_ctrl_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_ADDR   = 3'd1;
  localparam logic [2:0] REG_TXDATA = 3'd2;
  localparam logic [2:0] REG_RXDATA = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ACKERR  = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_LENERR  = 4;
  localparam int ST_TXFULL  = 5;
  localparam int ST_RXEMPTY = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_FALL = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/wb_i2c_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_i2c_ctrl_if : Wishbone-classic slave port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface wb_i2c_ctrl_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [2:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/i2c_byte_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_byte_fifo : 8-bit synchronous FIFO with show-ahead read data
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rp_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wp_d    = do_push ? wp_q + AW'(1) : wp_q;
    rp_d    = do_pop  ? rp_q + AW'(1) : rp_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end
endmodule
`default_nettype wire

// File: rtl/wb_i2c_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_i2c_ctrl : Wishbone register front-end that sequences i2c_master bytes
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_i2c_ctrl
  import wb_i2c_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  wb_i2c_ctrl_if.slave wb,
  output logic         irq,
  output logic         i2c_ena,
  output logic [6:0]   i2c_addr,
  output logic         i2c_rw,
  output logic [7:0]   i2c_wdata,
  input  logic         i2c_busy,
  input  logic [7:0]   i2c_rdata,
  input  logic         i2c_ackerr
);
  state_e          state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            ctrl_rw_q, ctrl_rw_d;
  logic [LW-1:0]   ctrl_len_q, ctrl_len_d, rem_q, rem_d;
  logic [6:0]      addr_q, addr_d, i2c_addr_q, i2c_addr_d;
  logic            done_q, done_d, ackerr_q, ackerr_d, ovf_q, ovf_d, lenerr_q, lenerr_d;
  logic            ena_q, ena_d, rw_q, rw_d, busy_prev_q, busy_prev_d;
  logic [7:0]      wdata_q, wdata_d;

  logic            tx_push, tx_pop, tx_full, tx_empty;
  logic            rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]      tx_rdata, rx_rdata;
  logic [LW-1:0]   tx_count, rx_count;

  logic            acc, wr, rd, start, len_bad, busy_rise, busy_fall, wrw;
  logic [LW-1:0]   wlen;
  logic            unused_sigs;

  i2c_byte_fifo #(.DEPTH(DEPTH), .CW(LW)) u_tx (
    .clk(clk), .reset(reset), .push(tx_push), .wdata(wb.wb_dat_i[7:0]), .pop(tx_pop),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  i2c_byte_fifo #(.DEPTH(DEPTH), .CW(LW)) u_rx (
    .clk(clk), .reset(reset), .push(rx_push), .wdata(i2c_rdata), .pop(rx_pop),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign acc       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr        = acc & wb.wb_we_i;
  assign rd        = acc & ~wb.wb_we_i;
  assign wrw       = wb.wb_dat_i[1];
  assign wlen      = wb.wb_dat_i[LW+7:8];
  assign start     = wr & (wb.wb_adr_i == REG_CTRL) & wb.wb_dat_i[0];
  assign busy_rise = i2c_busy & ~busy_prev_q;
  assign busy_fall = ~i2c_busy & busy_prev_q;
  assign len_bad   = (wlen == '0) || (wlen > LW'(DEPTH)) ||
                     (!wrw && (tx_count < wlen)) ||
                     (wrw && ((LW'(DEPTH) - rx_count) < wlen));
  assign unused_sigs = ^{wb.wb_dat_i[31:LW+8], tx_empty, rx_full};

  always_comb begin
    state_d     = state_q;
    ack_d       = acc;
    dat_d       = '0;
    ctrl_rw_d   = ctrl_rw_q;
    ctrl_len_d  = ctrl_len_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    i2c_addr_d  = i2c_addr_q;
    done_d      = done_q;
    ackerr_d    = ackerr_q;
    ovf_d       = ovf_q;
    lenerr_d    = lenerr_q;
    ena_d       = ena_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    busy_prev_d = i2c_busy;
    tx_push     = 1'b0;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    rx_pop      = 1'b0;

    if (wr) begin
      case (wb.wb_adr_i)
        REG_CTRL:   begin ctrl_rw_d = wrw; ctrl_len_d = wlen; end
        REG_ADDR:   addr_d = wb.wb_dat_i[6:0];
        REG_TXDATA: begin tx_push = 1'b1; if (tx_full) ovf_d = 1'b1; end
        REG_STATUS: begin
          if (wb.wb_dat_i[ST_DONE])   done_d   = 1'b0;
          if (wb.wb_dat_i[ST_ACKERR]) ackerr_d = 1'b0;
          if (wb.wb_dat_i[ST_OVF])    ovf_d    = 1'b0;
          if (wb.wb_dat_i[ST_LENERR]) lenerr_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (rd) begin
      case (wb.wb_adr_i)
        REG_CTRL:   dat_d = {{(24-LW){1'b0}}, ctrl_len_q, 6'b0, ctrl_rw_q, 1'b0};
        REG_ADDR:   dat_d = {25'b0, addr_q};
        REG_RXDATA: begin rx_pop = ~rx_empty; dat_d = rx_empty ? '0 : {24'b0, rx_rdata}; end
        REG_STATUS: dat_d = {25'b0, rx_empty, tx_full, lenerr_q, ovf_q, ackerr_q, done_q,
                             (state_q != S_IDLE)};
        default:    dat_d = '0;
      endcase
    end

    // FSM updates come last so a hardware set beats a same-cycle W1C.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_bad) begin
            lenerr_d = 1'b1;
          end else begin
            done_d     = 1'b0;
            ackerr_d   = 1'b0;
            rem_d      = wlen;
            i2c_addr_d = addr_q;
            rw_d       = wrw;
            ena_d      = 1'b1;
            state_d    = S_RISE;
            if (!wrw) begin tx_pop = 1'b1; wdata_d = tx_rdata; end
          end
        end
      end
      S_RISE: begin
        ackerr_d = ackerr_d | i2c_ackerr;
        if (busy_rise) begin
          rem_d   = rem_q - LW'(1);
          state_d = S_FALL;
          if (rem_q != LW'(1)) begin
            if (!rw_q) begin tx_pop = 1'b1; wdata_d = tx_rdata; end
          end else begin
            ena_d = 1'b0;
          end
        end
      end
      S_FALL: begin
        ackerr_d = ackerr_d | i2c_ackerr;
        if (busy_fall) begin
          rx_push = rw_q;
          state_d = ena_q ? S_RISE : S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      ctrl_rw_q   <= 1'b0;
      ctrl_len_q  <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      i2c_addr_q  <= '0;
      done_q      <= 1'b0;
      ackerr_q    <= 1'b0;
      ovf_q       <= 1'b0;
      lenerr_q    <= 1'b0;
      ena_q       <= 1'b0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      busy_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      ctrl_rw_q   <= ctrl_rw_d;
      ctrl_len_q  <= ctrl_len_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      i2c_addr_q  <= i2c_addr_d;
      done_q      <= done_d;
      ackerr_q    <= ackerr_d;
      ovf_q       <= ovf_d;
      lenerr_q    <= lenerr_d;
      ena_q       <= ena_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      busy_prev_q <= busy_prev_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq         = done_q;
  assign i2c_ena     = ena_q;
  assign i2c_addr    = i2c_addr_q;
  assign i2c_rw      = rw_q;
  assign i2c_wdata   = wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_i2c_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wb_i2c_ctrl : randomized register-level bench with a byte-level i2c model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_wb_i2c_ctrl;
  import wb_i2c_ctrl_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_i2c_ctrl_if wb();
  logic       irq, i2c_ena, i2c_rw, i2c_busy, i2c_ackerr;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_wdata, i2c_rdata;

  wb_i2c_ctrl #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset(reset), .wb(wb), .irq(irq),
    .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_wdata(i2c_wdata),
    .i2c_busy(i2c_busy), .i2c_rdata(i2c_rdata), .i2c_ackerr(i2c_ackerr)
  );

  // Byte-level stand-in for i2c_master plus a slave that answers at 0x58.
  logic [15:0] bus_q[$];
  logic [7:0]  slv_q[$];
  logic [1:0]  bm_st;
  int          bm_cnt;
  logic        bm_rw;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bm_st <= 2'd0; bm_cnt <= 0; bm_rw <= 1'b0;
      i2c_busy <= 1'b0; i2c_ackerr <= 1'b0; i2c_rdata <= 8'h00;
    end else begin
      case (bm_st)
        2'd0: if (i2c_ena) begin bm_st <= 2'd1; bm_cnt <= 2; end
        2'd1: if (bm_cnt == 0) begin
                i2c_busy   <= 1'b1;
                i2c_ackerr <= (i2c_addr != 7'h58);
                bm_rw      <= i2c_rw;
                bus_q.push_back({i2c_rw, i2c_addr, i2c_wdata});
                bm_st <= 2'd2; bm_cnt <= 5;
              end else bm_cnt <= bm_cnt - 1;
        2'd2: if (bm_cnt == 0) begin
                i2c_busy   <= 1'b0;
                i2c_ackerr <= 1'b0;
                if (bm_rw) i2c_rdata <= (slv_q.size() > 0) ? slv_q.pop_front() : 8'hFF;
                bm_st <= 2'd3; bm_cnt <= 2;
              end else bm_cnt <= bm_cnt - 1;
        default: if (bm_cnt == 0) bm_st <= 2'd0; else bm_cnt <= bm_cnt - 1;
      endcase
    end
  end

  // Reference model of the programmer-visible state.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit         m_done, m_ackerr, m_ovf, m_lenerr, m_crw;
  logic [6:0] m_addr;
  logic [LW-1:0] m_clen;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input bit we, input logic [2:0] adr, input logic [31:0] wd,
                         output logic [31:0] rdat);
    bit got = 1'b0;
    rdat = '0;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = wd;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wb.wb_ack_o) begin got = 1'b1; rdat = wb.wb_dat_o; end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wd, dummy);
  endtask

  function automatic logic [31:0] exp_status();
    return {25'b0, (m_rx.size() == 0), (m_tx.size() == DEPTH), m_lenerr, m_ovf,
            m_ackerr, m_done, 1'b0};
  endfunction

  task automatic check_status(input string tag);
    logic [31:0] v;
    wb_xfer(1'b0, REG_STATUS, '0, v);
    check(tag, v, exp_status());
    check({tag, "_irq"}, 32'(irq), 32'(m_done));
  endtask

  task automatic set_addr(input logic [6:0] a);
    wb_write(REG_ADDR, {25'b0, a});
    m_addr = a;
  endtask

  task automatic cpu_push(input logic [7:0] b);
    wb_write(REG_TXDATA, {24'b0, b});
    if (m_tx.size() == DEPTH) m_ovf = 1'b1;
    else m_tx.push_back(b);
  endtask

  task automatic cpu_pop(input string tag);
    logic [31:0] v;
    logic [7:0]  e;
    e = (m_rx.size() > 0) ? m_rx.pop_front() : 8'h00;
    wb_xfer(1'b0, REG_RXDATA, '0, v);
    check(tag, v, {24'b0, e});
  endtask

  task automatic w1c(input logic [31:0] m);
    wb_write(REG_STATUS, m);
    if (m[1]) m_done = 1'b0;
    if (m[2]) m_ackerr = 1'b0;
    if (m[3]) m_ovf = 1'b0;
    if (m[4]) m_lenerr = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    bit idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      wb_xfer(1'b0, REG_STATUS, '0, v);
      idle = !v[0];
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_xfer(input bit rw, input int len, input bit fixed, input bit poke);
    logic [15:0] exp_bus[$];
    logic [7:0]  b;
    logic [31:0] cw;
    bit          bad, seen;
    int          n;
    bad = (len == 0) || (len > DEPTH) || (!rw && m_tx.size() < len) ||
          (rw && (DEPTH - m_rx.size()) < len);
    bus_q.delete();
    slv_q.delete();
    cw = (32'(len) << 8) | (32'(rw) << 1) | 32'd1;
    m_crw = rw;
    m_clen = LW'(len);
    if (bad) begin
      m_lenerr = 1'b1;
      wb_write(REG_CTRL, cw);
      repeat (6) @(negedge clk);
      check("lenerr_ena", 32'(i2c_ena), 32'd0);
      check("lenerr_bus", 32'(bus_q.size()), 32'd0);
      check_status("lenerr_status");
      return;
    end
    for (int i = 0; i < len; i++) begin
      if (rw) begin
        b = fixed ? ((i == 0) ? 8'h55 : 8'hA3) : 8'($urandom);
        slv_q.push_back(b);
        m_rx.push_back(b);
        exp_bus.push_back({1'b1, m_addr, 8'h00});
      end else begin
        exp_bus.push_back({1'b0, m_addr, m_tx.pop_front()});
      end
    end
    wb_write(REG_CTRL, cw);
    if (poke) begin
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = i2c_busy; end
      check("poke_busy_seen", 32'(seen), 32'd1);
      wb_write(REG_CTRL, 32'h0000_0101);
      m_crw = 1'b0;
      m_clen = LW'(1);
    end
    wait_idle();
    m_done = 1'b1;
    m_ackerr = (m_addr != 7'h58);
    check("bus_count", 32'(bus_q.size()), 32'(len));
    n = (bus_q.size() < len) ? bus_q.size() : len;
    for (int i = 0; i < n; i++) begin
      if (rw) check("bus_rd", 32'(bus_q[i][15:8]), 32'(exp_bus[i][15:8]));
      else    check("bus_wr", 32'(bus_q[i]), 32'(exp_bus[i]));
    end
    check_status("xfer_status");
  endtask

  initial begin
    logic [31:0] v;
    bit          seen;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;   wb.wb_dat_i = '0;
    m_addr = '0; m_clen = '0;
    repeat (3) @(negedge clk);
    check("rst_ena", 32'(i2c_ena), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(wb.wb_ack_o), 32'd0);
    check("rst_i2c_addr", 32'(i2c_addr), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_status("rst_status");

    // Single-byte write to the responding slave.
    set_addr(7'h58);
    cpu_push(8'hBF);
    run_xfer(1'b0, 1, 1'b0, 1'b0);

    // Two-byte read, then drain past empty.
    run_xfer(1'b1, 2, 1'b1, 1'b0);
    cpu_pop("rx0");
    cpu_pop("rx1");
    cpu_pop("rx_empty_read");
    check_status("rx_drained");

    // Address NACK, then clear done and ackerr.
    set_addr(7'h23);
    cpu_push(8'($urandom));
    run_xfer(1'b0, 1, 1'b0, 1'b0);
    w1c(32'h6);
    check_status("w1c_status");

    // Overflow and oversize length.
    set_addr(7'h58);
    for (int i = 0; i < DEPTH + 1; i++) cpu_push(8'($urandom));
    check_status("ovf_status");
    run_xfer(1'b0, DEPTH + 1, 1'b0, 1'b0);

    // Start issued mid-transfer is ignored.
    run_xfer(1'b0, 3, 1'b0, 1'b1);
    wb_xfer(1'b0, REG_CTRL, '0, v);
    check("ctrl_readback", v, (32'(m_clen) << 8) | (32'(m_crw) << 1));

    // Reset in the middle of a byte.
    w1c(32'h1E);
    wb_write(REG_CTRL, (32'd2 << 8) | 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = i2c_busy; end
    check("rst_busy_seen", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1 check("rst_mid_ena", 32'(i2c_ena), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_tx.delete(); m_rx.delete(); bus_q.delete(); slv_q.delete();
    m_done = 1'b0; m_ackerr = 1'b0; m_ovf = 1'b0; m_lenerr = 1'b0;
    m_crw = 1'b0; m_clen = '0; m_addr = '0;
    @(negedge clk);
    wb_xfer(1'b0, REG_STATUS, '0, v);
    check("rst_mid_status", v, 32'h40);
    set_addr(7'h58);
    cpu_push(8'h3C);
    run_xfer(1'b0, 1, 1'b0, 1'b0);

    // Randomized mix of operations.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 6))
        0, 1: begin
          int k = $urandom_range(1, 3);
          for (int j = 0; j < k; j++) cpu_push(8'($urandom));
        end
        2: cpu_pop("rnd_pop");
        3: run_xfer(1'b0, $urandom_range(0, DEPTH + 1), 1'b0, 1'b0);
        4: run_xfer(1'b1, $urandom_range(0, DEPTH + 1), 1'b0, 1'b0);
        5: w1c(32'($urandom_range(0, 127)));
        default: set_addr(($urandom_range(0, 3) == 0) ? 7'h23 : 7'h58);
      endcase
      check_status("rnd_status");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
